aw_rr_arbiter: RTL and testbench
================================

Name: aw_rr_arbiter

Overview:
Round-robin arbiter that shares the single master-side AW channel of the write address decoder among NUM_MASTERS upstream masters. It holds each grant until the AW handshake completes and tags the forwarded request with the winner's ID. It records the grant order in a FIFO so the W-channel mux routes write data in AW order. It sits between the master ports and the write address decoder inside the interconnect.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ADDR_W, 32, address width
LEN_W, 8, burst length width
MST_ID_W, $clog2(NUM_MASTERS) (minimum 1), master ID width
ORDER_DEPTH, 4, order FIFO depth, power of 2 (2..16)

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
m_awaddr  in  NUM_MASTERS*ADDR_W  per-master address; master i occupies slice i
m_awlen  in  NUM_MASTERS*LEN_W  per-master burst length
m_awsize  in  NUM_MASTERS*3  per-master burst size
m_awburst  in  NUM_MASTERS*2  per-master burst type
m_awvalid  in  NUM_MASTERS  per-master request valid
m_awready  out  NUM_MASTERS  per-master ready
Master_AXI_awaddr  out  ADDR_W  forwarded address
Master_AXI_awlen  out  LEN_W  forwarded length
Master_AXI_awsize  out  3  forwarded size
Master_AXI_awburst  out  2  forwarded burst
Master_AXI_awvalid  out  1  forwarded valid
Master_AXI_awready  in  1  decoder ready
aw_master_id  out  MST_ID_W  ID of the currently granted master
wr_order_id  out  MST_ID_W  head of order FIFO; selects the W-channel source
wr_order_valid  out  1  order FIFO not empty
wlast_hs  in  1  W handshake carrying WLAST; pops the FIFO
order_full  out  1  order FIFO full

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_ptr=0; FIFO empty. All outputs are 0: Master_AXI_awvalid=0, m_awready=0, aw_master_id=0, wr_order_valid=0, order_full=0.
- State IDLE:
  - If any m_awvalid is high and the FIFO is not full, register the winner: the first requester at or above rr_ptr, searching upward with wrap.
  - Go to GRANT on the next cycle.
  - In IDLE, Master_AXI_awvalid=0 and m_awready=0.
- State GRANT:
  - The forwarded AW fields and aw_master_id are muxed from the registered grant g and stay stable.
  - Master_AXI_awvalid = m_awvalid[g]. m_awready[g] = Master_AXI_awready. All other m_awready bits are 0.
  - On handshake (Master_AXI_awvalid && Master_AXI_awready): push g into the FIFO, set rr_ptr = (g+1) mod NUM_MASTERS, go to IDLE.
  - The granted master must not drop awvalid before handshake (AXI rule). If it does, the arbiter stays in GRANT.
- Latency: 1 cycle from m_awvalid to Master_AXI_awvalid. At least 2 cycles per AW transaction (one IDLE bubble).
- Order FIFO:
  - Push only from GRANT on handshake. Pop on wlast_hs when wr_order_valid=1.
  - Push and pop in the same cycle: count unchanged; the head advances.
  - wlast_hs with the FIFO empty is ignored; count stays 0.
  - order_full = (count == ORDER_DEPTH). While full, IDLE does not grant, so no overflow is possible.
  - Read and write pointers wrap modulo ORDER_DEPTH. The count is ORDER_DEPTH-width+1 bits.
- Reset mid-GRANT: awvalid drops immediately, all FIFO entries are discarded, and rr_ptr returns to 0.

Optional Feature:
AW_ARB_QOS_EN
- Defined: adds input port m_awqos, NUM_MASTERS*4 bits. The IDLE winner is the requester with the highest awqos; ties are broken by round-robin from rr_ptr. Master_AXI_awqos (out, 4 bits) is forwarded from g.
- Undefined: pure round-robin. No qos ports exist.

Test Plan:
- Single request, M0 awaddr=0x1000 awlen=3, decoder ready=1 → Master_AXI_awvalid rises 1 cycle later with aw_master_id=0; m_awready[0] pulses 1 cycle; wr_order_id=0 and wr_order_valid=1 after handshake.
- M0 and M1 both valid continuously, ready=1 → grant order 0,1,0,1; one AW handshake every 2 cycles; FIFO holds 0,1 in order.
- Backpressure: M1 granted with Master_AXI_awready=0 for 5 cycles → fields stay stable, m_awready=0 throughout, M0 is not granted until M1's handshake.
- Fill FIFO: 4 handshakes with wlast_hs=0 → order_full=1, the 5th request waits in IDLE. One wlast_hs → the grant proceeds the next cycle.
- Simultaneous push/pop at count=2 → count stays 2, the head advances. wlast_hs with the FIFO empty → no change.
- Assert reset_n=0 mid-GRANT → Master_AXI_awvalid=0 asynchronously, wr_order_valid=0. After release, the first grant goes to M0.

Source files
------------

// File: rtl/aw_rr_arbiter.sv
// aw_rr_arbiter: round-robin AW arbiter in front of the write address decoder.
// Holds each grant until the AW handshake completes, tags it with the winner ID
// and records the grant order in a FIFO that steers the W-channel mux.
// Ports: clk, reset_n (async active-low); m_aw* per-master AW slices (master i
// at slice i) and m_awready; Master_AXI_aw* forwarded AW channel;
// aw_master_id current grant; wr_order_id/wr_order_valid order FIFO head;
// wlast_hs pops the head; order_full blocks new grants.
// Optional build macro AW_ARB_QOS_EN: adds m_awqos / Master_AXI_awqos and
// picks the highest-QoS requester, round-robin among equal QoS.
module aw_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 8,
  parameter int MST_ID_W    =
    (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1,
  parameter int ORDER_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr,
  input  logic [NUM_MASTERS*LEN_W-1:0]  m_awlen,
  input  logic [NUM_MASTERS*3-1:0]    m_awsize,
  input  logic [NUM_MASTERS*2-1:0]    m_awburst,
  input  logic [NUM_MASTERS-1:0]      m_awvalid,
  output logic [NUM_MASTERS-1:0]      m_awready,
  output logic [ADDR_W-1:0]           Master_AXI_awaddr,
  output logic [LEN_W-1:0]            Master_AXI_awlen,
  output logic [2:0]                  Master_AXI_awsize,
  output logic [1:0]                  Master_AXI_awburst,
  output logic                        Master_AXI_awvalid,
  input  logic                        Master_AXI_awready,
`ifdef AW_ARB_QOS_EN
  input  logic [NUM_MASTERS*4-1:0]    m_awqos,
  output logic [3:0]                  Master_AXI_awqos,
`endif
  output logic [MST_ID_W-1:0]         aw_master_id,
  output logic [MST_ID_W-1:0]         wr_order_id,
  output logic                        wr_order_valid,
  input  logic                        wlast_hs,
  output logic                        order_full
);

  localparam int PTR_W = $clog2(ORDER_DEPTH);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_nx;
  logic [MST_ID_W-1:0] g, g_nx;
  logic [MST_ID_W-1:0] rr_ptr, rr_nx;
  logic [MST_ID_W-1:0] winner;
  logic                found;
  logic                push, pop, hs;

  logic                sel_valid;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;
  logic [2:0]          sel_size;
  logic [1:0]          sel_burst;

  logic [MST_ID_W-1:0] mem [ORDER_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;

  // Two passes give the wrap-around search: rr_ptr..N-1, then 0..rr_ptr-1.
  // With QoS, a later candidate only wins on strictly higher QoS, so ties
  // fall to the earliest one in round-robin order.
  always_comb begin
    winner = '0;
    found  = 1'b0;
`ifdef AW_ARB_QOS_EN
    logic [3:0] best;
    best = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (i >= int'(rr_ptr) && m_awvalid[i] &&
          (!found || m_awqos[i*4 +: 4] > best)) begin
        found  = 1'b1;
        winner = MST_ID_W'(i);
        best   = m_awqos[i*4 +: 4];
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (i < int'(rr_ptr) && m_awvalid[i] &&
          (!found || m_awqos[i*4 +: 4] > best)) begin
        found  = 1'b1;
        winner = MST_ID_W'(i);
        best   = m_awqos[i*4 +: 4];
      end
    end
`else
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (i >= int'(rr_ptr) && m_awvalid[i] && !found) begin
        found  = 1'b1;
        winner = MST_ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (i < int'(rr_ptr) && m_awvalid[i] && !found) begin
        found  = 1'b1;
        winner = MST_ID_W'(i);
      end
    end
`endif
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (g == MST_ID_W'(i)) begin
        sel_valid = m_awvalid[i];
        sel_addr  = m_awaddr[i*ADDR_W +: ADDR_W];
        sel_len   = m_awlen[i*LEN_W +: LEN_W];
        sel_size  = m_awsize[i*3 +: 3];
        sel_burst = m_awburst[i*2 +: 2];
      end
    end
  end

  always_comb begin
    m_awready          = '0;
    Master_AXI_awvalid = 1'b0;
    Master_AXI_awaddr  = '0;
    Master_AXI_awlen   = '0;
    Master_AXI_awsize  = '0;
    Master_AXI_awburst = '0;
`ifdef AW_ARB_QOS_EN
    Master_AXI_awqos   = '0;
`endif
    if (state == GRANT) begin
      Master_AXI_awvalid = sel_valid;
      Master_AXI_awaddr  = sel_addr;
      Master_AXI_awlen   = sel_len;
      Master_AXI_awsize  = sel_size;
      Master_AXI_awburst = sel_burst;
`ifdef AW_ARB_QOS_EN
      for (int i = 0; i < NUM_MASTERS; i++)
        if (g == MST_ID_W'(i))
          Master_AXI_awqos = m_awqos[i*4 +: 4];
`endif
      for (int i = 0; i < NUM_MASTERS; i++)
        if (g == MST_ID_W'(i))
          m_awready[i] = Master_AXI_awready;
    end
  end

  assign hs = Master_AXI_awvalid && Master_AXI_awready;

  always_comb begin
    state_nx = state;
    g_nx     = g;
    rr_nx    = rr_ptr;
    push     = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && !order_full) begin
          g_nx     = winner;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (hs) begin
          push     = 1'b1;
          rr_nx    = (g == MST_ID_W'(NUM_MASTERS-1)) ?
                     '0 : g + 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      g      <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nx;
      g      <= g_nx;
      rr_ptr <= rr_nx;
    end
  end

  assign pop = wlast_hs && (count != '0);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= g;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign wr_order_valid = (count != '0);
  assign wr_order_id    = wr_order_valid ? mem[rd_ptr] : '0;
  assign order_full     = (count == (PTR_W+1)'(ORDER_DEPTH));
  assign aw_master_id   = g;

endmodule

// File: tb/tb_aw_rr_arbiter.sv
// tb_aw_rr_arbiter: directed self-checking bench for aw_rr_arbiter
// (2 masters, order FIFO depth 4).
module tb_aw_rr_arbiter;

  logic        clk;
  logic        reset_n;
  logic [63:0] m_awaddr;
  logic [15:0] m_awlen;
  logic [5:0]  m_awsize;
  logic [3:0]  m_awburst;
  logic [1:0]  m_awvalid;
  logic [1:0]  m_awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        ready;
  logic        aw_master_id;
  logic        wr_order_id;
  logic        wr_order_valid;
  logic        wlast_hs;
  logic        order_full;

  int checks;
  int failures;

  aw_rr_arbiter dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .m_awaddr           (m_awaddr),
    .m_awlen            (m_awlen),
    .m_awsize           (m_awsize),
    .m_awburst          (m_awburst),
    .m_awvalid          (m_awvalid),
    .m_awready          (m_awready),
    .Master_AXI_awaddr  (awaddr),
    .Master_AXI_awlen   (awlen),
    .Master_AXI_awsize  (awsize),
    .Master_AXI_awburst (awburst),
    .Master_AXI_awvalid (awvalid),
    .Master_AXI_awready (ready),
    .aw_master_id       (aw_master_id),
    .wr_order_id        (wr_order_id),
    .wr_order_valid     (wr_order_valid),
    .wlast_hs           (wlast_hs),
    .order_full         (order_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    m_awvalid = 2'b00;
    ready     = 1'b0;
    wlast_hs  = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    m_awvalid = 2'b11;
    ready     = 1'b1;
    wlast_hs  = 1'b0;
    step();
    checks++;
    if ({awvalid, m_awready, aw_master_id} !== 4'b0) begin
      failures++;
      $display("FAIL reset_aw: got v=%b rdy=%b id=%b want 0",
               awvalid, m_awready, aw_master_id);
    end
    checks++;
    if ({wr_order_valid, order_full, wr_order_id} !== 3'b0) begin
      failures++;
      $display("FAIL reset_fifo: got ov=%b full=%b oid=%b want 0",
               wr_order_valid, order_full, wr_order_id);
    end
    checks++;
    if ({awaddr, awlen} !== 40'h0) begin
      failures++;
      $display("FAIL reset_fields: got addr=%h len=%h want 0",
               awaddr, awlen);
    end
  endtask

  task automatic test_single();
    do_reset();
    m_awvalid = 2'b01;
    ready     = 1'b1;
    #1;
    checks++;
    if (awvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: got awvalid=%b want 0", awvalid);
    end
    step();
    checks++;
    if ({awvalid, aw_master_id, m_awready} !== 4'b1001) begin
      failures++;
      $display("FAIL single_grant: got v=%b id=%b rdy=%b want 1 0 01",
               awvalid, aw_master_id, m_awready);
    end
    checks++;
    if ({awaddr, awlen, awsize, awburst} !== {32'h1000, 8'd3, 3'd3, 2'b01}) begin
      failures++;
      $display("FAIL single_fields: got addr=%h len=%0d sz=%0d b=%b want 1000 3 3 01",
               awaddr, awlen, awsize, awburst);
    end
    checks++;
    if (wr_order_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pre_hs: got ov=%b want 0", wr_order_valid);
    end
    step();
    m_awvalid = 2'b00;
    #1;
    checks++;
    if ({awvalid, m_awready, wr_order_valid, wr_order_id} !== 5'b00010) begin
      failures++;
      $display("FAIL single_post: got v=%b rdy=%b ov=%b oid=%b want 0 00 1 0",
               awvalid, m_awready, wr_order_valid, wr_order_id);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready     = 1'b1;
    m_awvalid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({awvalid, aw_master_id} !== {1'b1, 1'(i % 2)}) begin
        failures++;
        $display("FAIL b2b_grant%0d: got v=%b id=%b want 1 %0d",
                 i, awvalid, aw_master_id, i % 2);
      end
      step();
      checks++;
      if (awvalid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_bubble%0d: got awvalid=%b want 0", i, awvalid);
      end
    end
    m_awvalid = 2'b00;
    checks++;
    if (order_full !== 1'b1) begin
      failures++;
      $display("FAIL b2b_full: got order_full=%b want 1", order_full);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({wr_order_valid, wr_order_id} !== {1'b1, 1'(i % 2)}) begin
        failures++;
        $display("FAIL b2b_order%0d: got ov=%b oid=%b want 1 %0d",
                 i, wr_order_valid, wr_order_id, i % 2);
      end
      wlast_hs = 1'b1;
      step();
      wlast_hs = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready     = 1'b0;
    m_awvalid = 2'b10;
    step();
    m_awvalid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({awvalid, aw_master_id, awaddr, awlen, m_awready} !==
          {1'b1, 1'b1, 32'h2000_0040, 8'd7, 2'b00}) begin
        failures++;
        $display("FAIL bp_hold%0d: got v=%b id=%b addr=%h len=%0d rdy=%b want 1 1 20000040 7 00",
                 i, awvalid, aw_master_id, awaddr, awlen, m_awready);
      end
      step();
    end
    ready = 1'b1;
    #1;
    checks++;
    if (m_awready !== 2'b10) begin
      failures++;
      $display("FAIL bp_ready: got m_awready=%b want 10", m_awready);
    end
    step();
    checks++;
    if (awvalid !== 1'b0) begin
      failures++;
      $display("FAIL bp_bubble: got awvalid=%b want 0", awvalid);
    end
    step();
    checks++;
    if ({awvalid, aw_master_id} !== 2'b10) begin
      failures++;
      $display("FAIL bp_next: got v=%b id=%b want 1 0",
               awvalid, aw_master_id);
    end
    m_awvalid = 2'b00;
  endtask

  task automatic test_fill_full();
    do_reset();
    ready     = 1'b1;
    m_awvalid = 2'b01;
    repeat (4) begin
      step();
      step();
    end
    checks++;
    if (order_full !== 1'b1) begin
      failures++;
      $display("FAIL fill_full: got order_full=%b want 1", order_full);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (awvalid !== 1'b0) begin
        failures++;
        $display("FAIL fill_wait%0d: got awvalid=%b want 0", i, awvalid);
      end
    end
    wlast_hs = 1'b1;
    step();
    wlast_hs = 1'b0;
    checks++;
    if ({order_full, awvalid} !== 2'b00) begin
      failures++;
      $display("FAIL fill_pop: got full=%b v=%b want 0 0",
               order_full, awvalid);
    end
    step();
    checks++;
    if ({awvalid, aw_master_id} !== 2'b10) begin
      failures++;
      $display("FAIL fill_resume: got v=%b id=%b want 1 0",
               awvalid, aw_master_id);
    end
    m_awvalid = 2'b00;
  endtask

  task automatic test_push_pop();
    do_reset();
    ready     = 1'b1;
    m_awvalid = 2'b11;
    repeat (4) step();
    m_awvalid = 2'b01;
    step();
    wlast_hs = 1'b1;
    step();
    wlast_hs  = 1'b0;
    m_awvalid = 2'b00;
    checks++;
    if ({wr_order_valid, wr_order_id, order_full} !== 3'b110) begin
      failures++;
      $display("FAIL pp_same: got ov=%b oid=%b full=%b want 1 1 0",
               wr_order_valid, wr_order_id, order_full);
    end
    wlast_hs = 1'b1;
    step();
    checks++;
    if ({wr_order_valid, wr_order_id} !== 2'b10) begin
      failures++;
      $display("FAIL pp_pop1: got ov=%b oid=%b want 1 0",
               wr_order_valid, wr_order_id);
    end
    step();
    checks++;
    if (wr_order_valid !== 1'b0) begin
      failures++;
      $display("FAIL pp_pop2: got ov=%b want 0", wr_order_valid);
    end
    step();
    wlast_hs = 1'b0;
    checks++;
    if ({wr_order_valid, order_full} !== 2'b00) begin
      failures++;
      $display("FAIL pp_empty_pop: got ov=%b full=%b want 0 0",
               wr_order_valid, order_full);
    end
    m_awvalid = 2'b01;
    step();
    step();
    m_awvalid = 2'b00;
    wlast_hs  = 1'b1;
    step();
    wlast_hs = 1'b0;
    checks++;
    if (wr_order_valid !== 1'b0) begin
      failures++;
      $display("FAIL pp_count: got ov=%b want 0 after one push one pop",
               wr_order_valid);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    ready     = 1'b1;
    m_awvalid = 2'b11;
    step();
    step();
    ready = 1'b0;
    step();
    checks++;
    if ({awvalid, aw_master_id, wr_order_valid} !== 3'b111) begin
      failures++;
      $display("FAIL rmg_pre: got v=%b id=%b ov=%b want 1 1 1",
               awvalid, aw_master_id, wr_order_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({awvalid, m_awready, wr_order_valid} !== 4'b0) begin
      failures++;
      $display("FAIL rmg_async: got v=%b rdy=%b ov=%b want 0",
               awvalid, m_awready, wr_order_valid);
    end
    step();
    reset_n = 1'b1;
    ready   = 1'b1;
    step();
    checks++;
    if ({awvalid, aw_master_id, wr_order_valid} !== 3'b100) begin
      failures++;
      $display("FAIL rmg_first: got v=%b id=%b ov=%b want 1 0 0",
               awvalid, aw_master_id, wr_order_valid);
    end
    m_awvalid = 2'b00;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_awaddr  = {32'h2000_0040, 32'h0000_1000};
    m_awlen   = {8'd7, 8'd3};
    m_awsize  = {3'd2, 3'd3};
    m_awburst = {2'b10, 2'b01};
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_fill_full();
    test_push_pop();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
